sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the sine generator. On a start request it drives the generator's `incr` and `en` inputs through a programmed staircase: `num_steps` frequency steps, each held for exactly `dwell` enabled cycles, with the phase increment changing by `step_incr` between steps. It sits directly upstream of the sine generator and is configured by the top level or testbench.

---
 rtl/sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer driving a sine generator's incr/en.
// Steps through num_steps increments, each held for dwell enabled cycles.
module sweep_ctrl #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned STEP_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   pause,
  input  logic [COUNT_WIDTH-1:0] start_incr,
  input  logic [COUNT_WIDTH-1:0] step_incr,
  input  logic                   down,
  input  logic [STEP_WIDTH-1:0]  num_steps,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [COUNT_WIDTH-1:0] incr,
  output logic                   en,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  step_idx
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_incr;
  logic [STEP_WIDTH-1:0]  r_step_idx;
  logic                   r_done;
  logic [DWELL_WIDTH-1:0] r_dcnt;
  logic [DWELL_WIDTH-1:0] r_dwell_l;
  logic [STEP_WIDTH-1:0]  r_last_l;
  logic                   r_down_l;
  logic [COUNT_WIDTH-1:0] r_step_l;

  logic [0:0]             w_state_nxt;
  logic [COUNT_WIDTH-1:0] w_incr_nxt;
  logic [STEP_WIDTH-1:0]  w_step_idx_nxt;
  logic                   w_done_nxt;
  logic [DWELL_WIDTH-1:0] w_dcnt_nxt;
  logic [DWELL_WIDTH-1:0] w_dwell_l_nxt;
  logic [STEP_WIDTH-1:0]  w_last_l_nxt;
  logic                   w_down_l_nxt;
  logic [COUNT_WIDTH-1:0] w_step_l_nxt;
  logic [DWELL_WIDTH-1:0] w_dwell_eff;
  logic [STEP_WIDTH-1:0]  w_last_eff;

  // Zero dwell / zero step count are promoted to one.
  assign w_dwell_eff = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
  assign w_last_eff  = (num_steps == '0) ? '0 : STEP_WIDTH'(num_steps - STEP_WIDTH'(1));

  // Next-state and datapath decode; everything holds unless a rule fires.
  always_comb begin
    w_state_nxt    = r_state;
    w_incr_nxt     = r_incr;
    w_step_idx_nxt = r_step_idx;
    w_done_nxt     = 1'b0;
    w_dcnt_nxt     = r_dcnt;
    w_dwell_l_nxt  = r_dwell_l;
    w_last_l_nxt   = r_last_l;
    w_down_l_nxt   = r_down_l;
    w_step_l_nxt   = r_step_l;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt    = S_RUN;
          w_incr_nxt     = start_incr;
          w_step_idx_nxt = '0;
          w_dcnt_nxt     = w_dwell_eff;
          w_dwell_l_nxt  = w_dwell_eff;
          w_last_l_nxt   = w_last_eff;
          w_down_l_nxt   = down;
          w_step_l_nxt   = step_incr;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_RUN;
        end else if (r_dcnt > DWELL_WIDTH'(1)) begin
          w_dcnt_nxt = r_dcnt - DWELL_WIDTH'(1);
        end else if (r_step_idx == r_last_l) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_step_idx_nxt = r_step_idx + STEP_WIDTH'(1);
          w_dcnt_nxt     = r_dwell_l;
          w_incr_nxt     = r_down_l ? (r_incr - r_step_l) : (r_incr + r_step_l);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_incr     <= '0;
      r_step_idx <= '0;
      r_done     <= 1'b0;
      r_dcnt     <= '0;
      r_dwell_l  <= '0;
      r_last_l   <= '0;
      r_down_l   <= 1'b0;
      r_step_l   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_incr     <= w_incr_nxt;
      r_step_idx <= w_step_idx_nxt;
      r_done     <= w_done_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_dwell_l  <= w_dwell_l_nxt;
      r_last_l   <= w_last_l_nxt;
      r_down_l   <= w_down_l_nxt;
      r_step_l   <= w_step_l_nxt;
    end
  end

  assign incr     = r_incr;
  assign step_idx = r_step_idx;
  assign done     = r_done;
  assign busy     = (r_state == S_RUN);
  assign en       = (r_state == S_RUN) && !pause;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl using a step-index/dwell reference model.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, pause, down;
  logic [7:0]  start_incr, step_incr, incr;
  logic [3:0]  num_steps, step_idx;
  logic [15:0] dwell;
  logic        en, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  sweep_ctrl #(.COUNT_WIDTH(8), .DWELL_WIDTH(16), .STEP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .start_incr(start_incr), .step_incr(step_incr), .down(down),
    .num_steps(num_steps), .dwell(dwell),
    .incr(incr), .en(en), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Increment for step s: start +/- s*step, modulo 256.
  function automatic logic [7:0] model_incr(input logic [7:0] si, input logic [7:0] st,
                                            input logic dn, input int s);
    int v;
    v = dn ? (int'(si) - s * int'(st)) : (int'(si) + s * int'(st));
    return 8'(v);
  endfunction

  // Runs one sweep from IDLE, checking every cycle against the model.
  task automatic run_sweep(input logic [7:0] si, input logic [7:0] st, input logic dn,
                           input logic [3:0] ns, input logic [15:0] dw,
                           input int pause_pct, input int pfrom, input int plen,
                           input int abort_at, input bit hold_start, input string tag);
    int nsteps, dwl, s, d, en_cnt, cyc;
    logic [14:0] exp_v, obs_v;
    logic [7:0]  last_incr;
    nsteps = (ns == 0) ? 1 : int'(ns);
    dwl    = (dw == 0) ? 1 : int'(dw);
    s = 0; d = 0; en_cnt = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; pause = 1'b0;
    start_incr = si; step_incr = st; down = dn; num_steps = ns; dwell = dw;
    #1;
    n_cmp++;
    if ({busy, en} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle_before_start: busy/en=%b required 00", tag, {busy, en});
    end
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    while (s < nsteps && cyc < 2000) begin
      if (!hold_start) begin
        start_incr = 8'($urandom); step_incr = 8'($urandom);
        down = 1'($urandom); num_steps = 4'($urandom); dwell = 16'($urandom);
      end
      pause = (cyc >= pfrom && cyc < pfrom + plen) ||
              (int'($urandom_range(0, 99)) < pause_pct);
      abort = (abort_at >= 0) && (en_cnt == abort_at);
      #1;
      exp_v = {1'b1, ~pause, 1'b0, 4'(s), model_incr(si, st, dn, s)};
      obs_v = {busy, en, done, step_idx, incr};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s run_cycle%0d: {busy,en,done,idx,incr}=%h required %h", tag, cyc, obs_v, exp_v);
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0; pause = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          exp_v = {3'b000, 4'(s), model_incr(si, st, dn, s)};
          obs_v = {busy, en, done, step_idx, incr};
          n_cmp++;
          if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s after_abort%0d: {busy,en,done,idx,incr}=%h required %h", tag, k, obs_v, exp_v);
          end
          @(negedge clk);
        end
        return;
      end
      if (!pause) begin
        en_cnt++;
        d++;
        if (d == dwl) begin
          d = 0;
          s++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (s < nsteps) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: step=%0d required %0d", tag, s, nsteps);
      return;
    end
    pause = 1'b0; abort = 1'b0;
    if (hold_start) begin
      start_incr = 8'($urandom); step_incr = 8'd1; down = 1'b0; num_steps = 4'd2; dwell = 16'd3;
    end
    last_incr = model_incr(si, st, dn, nsteps - 1);
    #1;
    exp_v = {3'b001, 4'(nsteps - 1), last_incr};
    obs_v = {busy, en, done, step_idx, incr};
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s done_cycle: {busy,en,done,idx,incr}=%h required %h", tag, obs_v, exp_v);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    if (hold_start) begin
      exp_v = {3'b110, 4'd0, start_incr};
    end else begin
      exp_v = {3'b000, 4'(nsteps - 1), last_incr};
    end
    obs_v = {busy, en, done, step_idx, incr};
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s after_done: {busy,en,done,idx,incr}=%h required %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; down = 1'b0;
    start_incr = '0; step_incr = '0; num_steps = '0; dwell = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, en, done, step_idx, incr} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: {busy,en,done,idx,incr}=%h required 0000", {busy, en, done, step_idx, incr});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_sweep(8'd4, 8'd2, 1'b0, 4'd3, 16'd5, 0, 0, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_wrap_down();
    run_sweep(8'd250, 8'd10, 1'b0, 4'd2, 16'd1, 0, 0, 0, -1, 1'b0, "wrap_up");
    run_sweep(8'd3, 8'd5, 1'b1, 4'd2, 16'd1, 0, 0, 0, -1, 1'b0, "wrap_down");
  endtask

  task automatic test_degenerate();
    run_sweep(8'd77, 8'd9, 1'b0, 4'd0, 16'd0, 0, 0, 0, -1, 1'b0, "degenerate");
  endtask

  task automatic test_pause();
    run_sweep(8'd10, 8'd3, 1'b0, 4'd2, 16'd4, 0, 1, 3, -1, 1'b0, "pause");
  endtask

  task automatic test_abort();
    run_sweep(8'd20, 8'd4, 1'b0, 4'd4, 16'd3, 0, 0, 0, 4, 1'b0, "abort");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; abort = 1'b0; pause = 1'b0;
    start_incr = 8'd40; step_incr = 8'd7; down = 1'b0; num_steps = 4'd5; dwell = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, en, done, step_idx, incr} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: {busy,en,done,idx,incr}=%h required 0000", {busy, en, done, step_idx, incr});
    end
  endtask

  task automatic test_start_held();
    run_sweep(8'd100, 8'd1, 1'b1, 4'd2, 16'd2, 0, 0, 0, -1, 1'b1, "start_held");
    apply_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_sweep(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom_range(0, 5)),
                16'($urandom_range(0, 5)), 25, 0, 0,
                (i % 4 == 3) ? int'($urandom_range(0, 3)) : -1, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_sweep(8'd1, 8'd1, 1'b0, 4'd2, 16'd2, 0, 0, 0, -1, 1'b0, "b2b_a");
    run_sweep(8'd200, 8'd50, 1'b0, 4'd3, 16'd1, 0, 0, 0, -1, 1'b0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_down();
    test_degenerate();
    test_pause();
    test_abort();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
